// File: rtl/craps_pkg.sv
// -----------------------------------------------------------------------------
// craps_pkg
// Shared types and constants for the craps game controller: the FSM state
// enumeration, die legality bounds, the winning/losing come-out totals, and
// small helper functions used by the controller.
// -----------------------------------------------------------------------------
package craps_pkg;

    typedef enum logic [2:0] {
        COME_OUT   = 3'd0,
        SPIN_CO    = 3'd1,
        POINT_WAIT = 3'd2,
        SPIN_PT    = 3'd3,
        WIN        = 3'd4,
        LOSE       = 3'd5
    } state_e;

    localparam logic [3:0] DIE_MIN    = 4'd1;
    localparam logic [3:0] DIE_MAX    = 4'd6;
    localparam logic [3:0] NATURAL_7  = 4'd7;
    localparam logic [3:0] NATURAL_11 = 4'd11;
    localparam logic [3:0] CRAPS_2    = 4'd2;
    localparam logic [3:0] CRAPS_3    = 4'd3;
    localparam logic [3:0] CRAPS_12   = 4'd12;

    // A die face is legal only inside 1..6.
    function automatic logic die_ok(input logic [3:0] d);
        return (d >= DIE_MIN) && (d <= DIE_MAX);
    endfunction

    // Saturating 8-bit increment for the game tallies.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer followed by a stability-counting debouncer. The output
// level follows the synchronized input only after that input has differed
// from the current output for DEBOUNCE_CYC consecutive clocks.
// Ports:
//   clk_i    - clock
//   reset_i  - synchronous active-high reset (clears sync chain and output)
//   btn_i    - raw asynchronous button
//   btn_db_o - debounced level
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int CNT_W        = 20
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic btn_db_o
);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_q;
    logic             db_d;

    // Count consecutive cycles where the synchronized input disagrees with
    // the accepted level; flip the level on the DEBOUNCE_CYC-th such cycle.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                db_d  = sync_q[1];
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchronizer chain and debouncer state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= 2'b00;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign btn_db_o = db_q;

endmodule

// File: rtl/craps_controller.sv
// -----------------------------------------------------------------------------
// craps_controller
// Game controller for a two-dice craps table. A debounced roll button spins
// the dice counters; on release the dice are sampled and the come-out or
// point roll is resolved on the same clock edge.
// Ports:
//   clk_in          - 100 MHz clock
//   reset           - synchronous active-high reset
//   roll_btn        - raw roll button (high = pressed)
//   die_a, die_b    - live die values (legal 1..6)
//   dice_en         - enable to dice counters, high while spinning
//   sum             - total of last accepted roll
//   point           - established point (0 = none)
//   win, lose       - high throughout WIN / LOSE
//   bad_roll        - one-cycle pulse on an illegal die at release
//   state_o         - FSM state encoding
//   wins, losses    - saturating game tallies
// Optional feature macro: CRAPS_STATS_EN enables the wins/losses tallies;
// when undefined both tallies are constant 0.
// -----------------------------------------------------------------------------
module craps_controller
    import craps_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int CNT_W        = 20
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       roll_btn,
    input  logic [3:0] die_a,
    input  logic [3:0] die_b,
    output logic       dice_en,
    output logic [3:0] sum,
    output logic [3:0] point,
    output logic       win,
    output logic       lose,
    output logic       bad_roll,
    output logic [2:0] state_o,
    output logic [7:0] wins,
    output logic [7:0] losses
);

    logic       btn_db;
    logic [4:0] add_d;
    logic [3:0] roll_d;
    logic       dice_ok_d;

    state_e     state_q;
    logic [3:0] sum_q;
    logic [3:0] point_q;
    logic       dice_en_q;
    logic       win_q;
    logic       lose_q;
    logic       bad_q;
`ifdef CRAPS_STATS_EN
    logic [7:0] wins_q;
    logic [7:0] losses_q;
`endif

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) u_btn_debounce (
        .clk_i    (clk_in),
        .reset_i  (reset),
        .btn_i    (roll_btn),
        .btn_db_o (btn_db)
    );

    // Roll total (5-bit add truncated to 4 bits) and die legality.
    always_comb begin
        add_d     = {1'b0, die_a} + {1'b0, die_b};
        roll_d    = add_d[3:0];
        dice_ok_d = die_ok(die_a) && die_ok(die_b);
    end

    // Game FSM with registered outputs; a roll resolves on the first edge
    // that sees the debounced button low while spinning.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= COME_OUT;
            sum_q     <= 4'd0;
            point_q   <= 4'd0;
            dice_en_q <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            bad_q     <= 1'b0;
`ifdef CRAPS_STATS_EN
            wins_q    <= 8'd0;
            losses_q  <= 8'd0;
`endif
        end else begin
            bad_q <= 1'b0;
            case (state_q)
                COME_OUT: begin
                    if (btn_db) begin
                        state_q   <= SPIN_CO;
                        dice_en_q <= 1'b1;
                    end
                end
                POINT_WAIT: begin
                    if (btn_db) begin
                        state_q   <= SPIN_PT;
                        dice_en_q <= 1'b1;
                    end
                end
                WIN, LOSE: begin
                    // A new game starts: drop the old point and result.
                    if (btn_db) begin
                        state_q   <= SPIN_CO;
                        dice_en_q <= 1'b1;
                        win_q     <= 1'b0;
                        lose_q    <= 1'b0;
                        point_q   <= 4'd0;
                    end
                end
                SPIN_CO: begin
                    if (!btn_db) begin
                        dice_en_q <= 1'b0;
                        if (!dice_ok_d) begin
                            bad_q   <= 1'b1;
                            state_q <= COME_OUT;
                        end else begin
                            sum_q <= roll_d;
                            if ((roll_d == NATURAL_7) || (roll_d == NATURAL_11)) begin
                                state_q <= WIN;
                                win_q   <= 1'b1;
`ifdef CRAPS_STATS_EN
                                wins_q  <= sat_inc8(wins_q);
`endif
                            end else if ((roll_d == CRAPS_2) || (roll_d == CRAPS_3) ||
                                         (roll_d == CRAPS_12)) begin
                                state_q  <= LOSE;
                                lose_q   <= 1'b1;
`ifdef CRAPS_STATS_EN
                                losses_q <= sat_inc8(losses_q);
`endif
                            end else begin
                                state_q <= POINT_WAIT;
                                point_q <= roll_d;
                            end
                        end
                    end
                end
                SPIN_PT: begin
                    if (!btn_db) begin
                        dice_en_q <= 1'b0;
                        if (!dice_ok_d) begin
                            bad_q   <= 1'b1;
                            state_q <= POINT_WAIT;
                        end else begin
                            sum_q <= roll_d;
                            if (roll_d == point_q) begin
                                state_q <= WIN;
                                win_q   <= 1'b1;
`ifdef CRAPS_STATS_EN
                                wins_q  <= sat_inc8(wins_q);
`endif
                            end else if (roll_d == NATURAL_7) begin
                                state_q  <= LOSE;
                                lose_q   <= 1'b1;
`ifdef CRAPS_STATS_EN
                                losses_q <= sat_inc8(losses_q);
`endif
                            end else begin
                                state_q <= POINT_WAIT;
                            end
                        end
                    end
                end
                default: begin
                    state_q   <= COME_OUT;
                    dice_en_q <= 1'b0;
                    win_q     <= 1'b0;
                    lose_q    <= 1'b0;
                end
            endcase
        end
    end

    assign dice_en  = dice_en_q;
    assign sum      = sum_q;
    assign point    = point_q;
    assign win      = win_q;
    assign lose     = lose_q;
    assign bad_roll = bad_q;
    assign state_o  = state_q;
`ifdef CRAPS_STATS_EN
    assign wins     = wins_q;
    assign losses   = losses_q;
`else
    assign wins     = 8'd0;
    assign losses   = 8'd0;
`endif

endmodule
